// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module      : alu_rs
// Description : Reservation station and issue scheduler for the integer ALU.
//               Buffers dispatched instructions until both operands are known,
//               snoops the ALU and LSB result buses to fill pending operands,
//               and issues at most one ready instruction per cycle through
//               registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rs #(
    parameter int RS_SIZE    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int OP_WIDTH   = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clr_in,

    input  logic                  disp_valid_in,
    input  logic [OP_WIDTH-1:0]   disp_op_in,
    input  logic [DATA_WIDTH-1:0] disp_vj_in,
    input  logic [DATA_WIDTH-1:0] disp_vk_in,
    input  logic                  disp_qj_pending_in,
    input  logic                  disp_qk_pending_in,
    input  logic [ROB_WIDTH-1:0]  disp_qj_in,
    input  logic [ROB_WIDTH-1:0]  disp_qk_in,
    input  logic [DATA_WIDTH-1:0] disp_imm_in,
    input  logic [ROB_WIDTH-1:0]  disp_rob_id_in,
    output logic                  full_out,

    input  logic                  alu_cdb_valid_in,
    input  logic [ROB_WIDTH-1:0]  alu_cdb_rob_id_in,
    input  logic [DATA_WIDTH-1:0] alu_cdb_data_in,
    input  logic                  lsb_cdb_valid_in,
    input  logic [ROB_WIDTH-1:0]  lsb_cdb_rob_id_in,
    input  logic [DATA_WIDTH-1:0] lsb_cdb_data_in,

    output logic                  issue_valid_out,
    output logic [OP_WIDTH-1:0]   issue_op_out,
    output logic [DATA_WIDTH-1:0] issue_vj_out,
    output logic [DATA_WIDTH-1:0] issue_vk_out,
    output logic [DATA_WIDTH-1:0] issue_imm_out,
    output logic [ROB_WIDTH-1:0]  issue_rob_id_out
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic                  busy;
        logic [OP_WIDTH-1:0]   op;
        logic [DATA_WIDTH-1:0] vj;
        logic [ROB_WIDTH-1:0]  qj;
        logic                  qj_pend;
        logic [DATA_WIDTH-1:0] vk;
        logic [ROB_WIDTH-1:0]  qk;
        logic                  qk_pend;
        logic [DATA_WIDTH-1:0] imm;
        logic [ROB_WIDTH-1:0]  rob_id;
    } entry_t;

    typedef struct packed {
        logic                  pend;
        logic [DATA_WIDTH-1:0] val;
    } opnd_t;

    entry_t                ent_q [RS_SIZE];
    entry_t                ent_d [RS_SIZE];

    logic                  issue_valid_q,  issue_valid_d;
    logic [OP_WIDTH-1:0]   issue_op_q,     issue_op_d;
    logic [DATA_WIDTH-1:0] issue_vj_q,     issue_vj_d;
    logic [DATA_WIDTH-1:0] issue_vk_q,     issue_vk_d;
    logic [DATA_WIDTH-1:0] issue_imm_q,    issue_imm_d;
    logic [ROB_WIDTH-1:0]  issue_rob_id_q, issue_rob_id_d;

    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic                  sel_found;
    logic [IDX_W-1:0]      sel_idx;

    // Resolve one operand against both result buses; the ALU bus has priority
    // when both carry the same tag.
    function automatic opnd_t snoop(input logic                  pend,
                                    input logic [ROB_WIDTH-1:0]  tag,
                                    input logic [DATA_WIDTH-1:0] val);
        opnd_t r;
        r.pend = pend;
        r.val  = val;
        if (pend) begin
            if (alu_cdb_valid_in && (alu_cdb_rob_id_in == tag)) begin
                r.pend = 1'b0;
                r.val  = alu_cdb_data_in;
            end else if (lsb_cdb_valid_in && (lsb_cdb_rob_id_in == tag)) begin
                r.pend = 1'b0;
                r.val  = lsb_cdb_data_in;
            end
        end
        return r;
    endfunction

    // Priority encoders on registered state: lowest free slot and lowest ready entry.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!ent_q[i].busy) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ent_q[i].busy && !ent_q[i].qj_pend && !ent_q[i].qk_pend) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Full reflects current register state only; a same-cycle issue frees a slot next cycle.
    assign full_out = !free_found;

    // Next-state: flush dominates; otherwise wakeup, issue and dispatch on disjoint entries.
    always_comb begin
        opnd_t wj;
        opnd_t wk;
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
        end
        issue_valid_d  = issue_valid_q;
        issue_op_d     = issue_op_q;
        issue_vj_d     = issue_vj_q;
        issue_vk_d     = issue_vk_q;
        issue_imm_d    = issue_imm_q;
        issue_rob_id_d = issue_rob_id_q;
        wj             = '0;
        wk             = '0;

        if (clr_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_d[i].busy = 1'b0;
            end
            issue_valid_d = 1'b0;
        end else begin
            // Wakeup of busy entries waiting on a broadcast tag.
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].busy) begin
                    wj = snoop(ent_q[i].qj_pend, ent_q[i].qj, ent_q[i].vj);
                    wk = snoop(ent_q[i].qk_pend, ent_q[i].qk, ent_q[i].vk);
                    ent_d[i].qj_pend = wj.pend;
                    ent_d[i].vj      = wj.val;
                    ent_d[i].qk_pend = wk.pend;
                    ent_d[i].vk      = wk.val;
                end
            end

            // Issue the selected entry; data outputs hold when nothing is ready.
            if (sel_found) begin
                issue_valid_d         = 1'b1;
                issue_op_d            = ent_q[sel_idx].op;
                issue_vj_d            = ent_q[sel_idx].vj;
                issue_vk_d            = ent_q[sel_idx].vk;
                issue_imm_d           = ent_q[sel_idx].imm;
                issue_rob_id_d        = ent_q[sel_idx].rob_id;
                ent_d[sel_idx].busy   = 1'b0;
            end else begin
                issue_valid_d = 1'b0;
            end

            // Dispatch into the lowest free slot, forwarding same-cycle broadcasts.
            if (disp_valid_in && free_found) begin
                wj = snoop(disp_qj_pending_in, disp_qj_in, disp_vj_in);
                wk = snoop(disp_qk_pending_in, disp_qk_in, disp_vk_in);
                ent_d[free_idx].busy    = 1'b1;
                ent_d[free_idx].op      = disp_op_in;
                ent_d[free_idx].vj      = wj.val;
                ent_d[free_idx].qj      = disp_qj_in;
                ent_d[free_idx].qj_pend = wj.pend;
                ent_d[free_idx].vk      = wk.val;
                ent_d[free_idx].qk      = disp_qk_in;
                ent_d[free_idx].qk_pend = wk.pend;
                ent_d[free_idx].imm     = disp_imm_in;
                ent_d[free_idx].rob_id  = disp_rob_id_in;
            end
        end
    end

    // State registers: asynchronous reset, frozen while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            issue_valid_q  <= 1'b0;
            issue_op_q     <= '0;
            issue_vj_q     <= '0;
            issue_vk_q     <= '0;
            issue_imm_q    <= '0;
            issue_rob_id_q <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= ent_d[i];
            end
            issue_valid_q  <= issue_valid_d;
            issue_op_q     <= issue_op_d;
            issue_vj_q     <= issue_vj_d;
            issue_vk_q     <= issue_vk_d;
            issue_imm_q    <= issue_imm_d;
            issue_rob_id_q <= issue_rob_id_d;
        end
    end

    assign issue_valid_out  = issue_valid_q;
    assign issue_op_out     = issue_op_q;
    assign issue_vj_out     = issue_vj_q;
    assign issue_vk_out     = issue_vk_q;
    assign issue_imm_out    = issue_imm_q;
    assign issue_rob_id_out = issue_rob_id_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rs
// Description : Self-checking bench for alu_rs: directed scenarios followed by
//               randomized traffic, all compared against a slot-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rs;

    localparam int RS_SIZE = 8;
    localparam int DW      = 32;
    localparam int RW      = 4;
    localparam int OW      = 6;

    localparam logic [OW-1:0] OP_ADD = 6'd1;
    localparam logic [OW-1:0] OP_SUB = 6'd2;
    localparam logic [OW-1:0] OP_AND = 6'd3;

    logic          clk_in;
    logic          rst_in;
    logic          rdy_in;
    logic          clr_in;
    logic          disp_valid_in;
    logic [OW-1:0] disp_op_in;
    logic [DW-1:0] disp_vj_in;
    logic [DW-1:0] disp_vk_in;
    logic          disp_qj_pending_in;
    logic          disp_qk_pending_in;
    logic [RW-1:0] disp_qj_in;
    logic [RW-1:0] disp_qk_in;
    logic [DW-1:0] disp_imm_in;
    logic [RW-1:0] disp_rob_id_in;
    logic          full_out;
    logic          alu_cdb_valid_in;
    logic [RW-1:0] alu_cdb_rob_id_in;
    logic [DW-1:0] alu_cdb_data_in;
    logic          lsb_cdb_valid_in;
    logic [RW-1:0] lsb_cdb_rob_id_in;
    logic [DW-1:0] lsb_cdb_data_in;
    logic          issue_valid_out;
    logic [OW-1:0] issue_op_out;
    logic [DW-1:0] issue_vj_out;
    logic [DW-1:0] issue_vk_out;
    logic [DW-1:0] issue_imm_out;
    logic [RW-1:0] issue_rob_id_out;

    alu_rs #(
        .RS_SIZE   (RS_SIZE),
        .DATA_WIDTH(DW),
        .ROB_WIDTH (RW),
        .OP_WIDTH  (OW)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .clr_in             (clr_in),
        .disp_valid_in      (disp_valid_in),
        .disp_op_in         (disp_op_in),
        .disp_vj_in         (disp_vj_in),
        .disp_vk_in         (disp_vk_in),
        .disp_qj_pending_in (disp_qj_pending_in),
        .disp_qk_pending_in (disp_qk_pending_in),
        .disp_qj_in         (disp_qj_in),
        .disp_qk_in         (disp_qk_in),
        .disp_imm_in        (disp_imm_in),
        .disp_rob_id_in     (disp_rob_id_in),
        .full_out           (full_out),
        .alu_cdb_valid_in   (alu_cdb_valid_in),
        .alu_cdb_rob_id_in  (alu_cdb_rob_id_in),
        .alu_cdb_data_in    (alu_cdb_data_in),
        .lsb_cdb_valid_in   (lsb_cdb_valid_in),
        .lsb_cdb_rob_id_in  (lsb_cdb_rob_id_in),
        .lsb_cdb_data_in    (lsb_cdb_data_in),
        .issue_valid_out    (issue_valid_out),
        .issue_op_out       (issue_op_out),
        .issue_vj_out       (issue_vj_out),
        .issue_vk_out       (issue_vk_out),
        .issue_imm_out      (issue_imm_out),
        .issue_rob_id_out   (issue_rob_id_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Reference model: a table of waiting instructions plus the last issued one.
    bit            m_busy [RS_SIZE];
    logic [OW-1:0] m_op   [RS_SIZE];
    logic [DW-1:0] m_vj   [RS_SIZE];
    logic [DW-1:0] m_vk   [RS_SIZE];
    logic [DW-1:0] m_imm  [RS_SIZE];
    logic [RW-1:0] m_qj   [RS_SIZE];
    logic [RW-1:0] m_qk   [RS_SIZE];
    logic [RW-1:0] m_rob  [RS_SIZE];
    bit            m_pj   [RS_SIZE];
    bit            m_pk   [RS_SIZE];
    bit            m_iv;
    logic [OW-1:0] m_iop;
    logic [DW-1:0] m_ivj, m_ivk, m_iimm;
    logic [RW-1:0] m_irob;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_busy();
        int n = 0;
        for (int i = 0; i < RS_SIZE; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic bit cdb_hit(input logic [RW-1:0] tag, output logic [DW-1:0] d);
        d = '0;
        if (alu_cdb_valid_in && alu_cdb_rob_id_in == tag) begin
            d = alu_cdb_data_in;
            return 1'b1;
        end
        if (lsb_cdb_valid_in && lsb_cdb_rob_id_in == tag) begin
            d = lsb_cdb_data_in;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < RS_SIZE; i++) begin
            m_busy[i] = 0; m_op[i] = '0; m_vj[i] = '0; m_vk[i] = '0; m_imm[i] = '0;
            m_qj[i] = '0; m_qk[i] = '0; m_rob[i] = '0; m_pj[i] = 0; m_pk[i] = 0;
        end
        m_iv = 0; m_iop = '0; m_ivj = '0; m_ivk = '0; m_iimm = '0; m_irob = '0;
    endtask

    task automatic m_step();
        int sel = -1;
        int fr  = -1;
        logic [DW-1:0] d;
        if (!rdy_in) return;
        if (clr_in) begin
            for (int i = 0; i < RS_SIZE; i++) m_busy[i] = 0;
            m_iv = 0;
            return;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (sel < 0 && m_busy[i] && !m_pj[i] && !m_pk[i]) sel = i;
            if (fr < 0 && !m_busy[i]) fr = i;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (m_busy[i] && m_pj[i] && cdb_hit(m_qj[i], d)) begin m_pj[i] = 0; m_vj[i] = d; end
            if (m_busy[i] && m_pk[i] && cdb_hit(m_qk[i], d)) begin m_pk[i] = 0; m_vk[i] = d; end
        end
        if (sel >= 0) begin
            m_iv = 1; m_iop = m_op[sel]; m_ivj = m_vj[sel]; m_ivk = m_vk[sel];
            m_iimm = m_imm[sel]; m_irob = m_rob[sel]; m_busy[sel] = 0;
        end else begin
            m_iv = 0;
        end
        if (disp_valid_in && fr >= 0) begin
            m_busy[fr] = 1; m_op[fr] = disp_op_in; m_imm[fr] = disp_imm_in; m_rob[fr] = disp_rob_id_in;
            m_qj[fr] = disp_qj_in; m_qk[fr] = disp_qk_in;
            m_vj[fr] = disp_vj_in; m_pj[fr] = disp_qj_pending_in;
            m_vk[fr] = disp_vk_in; m_pk[fr] = disp_qk_pending_in;
            if (m_pj[fr] && cdb_hit(m_qj[fr], d)) begin m_pj[fr] = 0; m_vj[fr] = d; end
            if (m_pk[fr] && cdb_hit(m_qk[fr], d)) begin m_pk[fr] = 0; m_vk[fr] = d; end
        end
    endtask

    task automatic compare_all(input string where);
        check({where, ".valid"}, 32'(issue_valid_out), 32'(m_iv));
        check({where, ".op"},    32'(issue_op_out),    32'(m_iop));
        check({where, ".vj"},    issue_vj_out,         m_ivj);
        check({where, ".vk"},    issue_vk_out,         m_ivk);
        check({where, ".imm"},   issue_imm_out,        m_iimm);
        check({where, ".rob"},   32'(issue_rob_id_out), 32'(m_irob));
        check({where, ".full"},  32'(full_out),        32'(count_busy() == RS_SIZE));
    endtask

    task automatic idle();
        rdy_in = 1'b1; clr_in = 1'b0; disp_valid_in = 1'b0;
        alu_cdb_valid_in = 1'b0; lsb_cdb_valid_in = 1'b0;
    endtask

    task automatic set_disp(input logic [OW-1:0] op, input logic [DW-1:0] vj, input logic pj,
                            input logic [RW-1:0] qj, input logic [DW-1:0] vk, input logic pk,
                            input logic [RW-1:0] qk, input logic [DW-1:0] imm, input logic [RW-1:0] rob);
        disp_valid_in = 1'b1; disp_op_in = op; disp_vj_in = vj; disp_qj_pending_in = pj;
        disp_qj_in = qj; disp_vk_in = vk; disp_qk_pending_in = pk; disp_qk_in = qk;
        disp_imm_in = imm; disp_rob_id_in = rob;
    endtask

    task automatic tick(input string where);
        @(posedge clk_in);
        m_step();
        #1;
        compare_all(where);
    endtask

    initial begin
        rst_in = 1'b1;
        idle();
        set_disp('0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        disp_valid_in = 1'b0;
        alu_cdb_rob_id_in = '0; alu_cdb_data_in = '0;
        lsb_cdb_rob_id_in = '0; lsb_cdb_data_in = '0;
        m_reset();
        #2;
        compare_all("reset");
        #10 rst_in = 1'b0;

        // Ready ADD issues one edge after it is written.
        set_disp(OP_ADD, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 32'd0, 4'd3);
        tick("add_disp"); idle();
        check("add_not_yet", 32'(issue_valid_out), 32'd0);
        tick("add_iss");
        check("add_valid", 32'(issue_valid_out), 32'd1);
        check("add_op", 32'(issue_op_out), 32'(OP_ADD));
        check("add_vj", issue_vj_out, 32'd5);
        check("add_vk", issue_vk_out, 32'd7);
        check("add_rob", 32'(issue_rob_id_out), 32'd3);
        tick("add_drop");
        check("add_one_cycle", 32'(issue_valid_out), 32'd0);

        // SUB waits on tag 2, woken by the ALU bus three cycles later.
        set_disp(OP_SUB, 32'hDEAD, 1'b1, 4'd2, 32'd9, 1'b0, 4'd0, 32'd1, 4'd4);
        tick("sub_disp"); idle();
        repeat (3) begin
            tick("sub_wait");
            check("sub_waiting", 32'(issue_valid_out), 32'd0);
        end
        alu_cdb_valid_in = 1'b1; alu_cdb_rob_id_in = 4'd2; alu_cdb_data_in = 32'h10;
        tick("sub_wake"); idle();
        tick("sub_iss");
        check("sub_valid", 32'(issue_valid_out), 32'd1);
        check("sub_vj", issue_vj_out, 32'h10);
        check("sub_rob", 32'(issue_rob_id_out), 32'd4);

        // Dispatch-time forwarding from the LSB bus.
        set_disp(OP_AND, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'd2, 4'd5);
        lsb_cdb_valid_in = 1'b1; lsb_cdb_rob_id_in = 4'd6; lsb_cdb_data_in = 32'hAB;
        tick("fwd_disp"); idle();
        tick("fwd_iss");
        check("fwd_valid", 32'(issue_valid_out), 32'd1);
        check("fwd_vk", issue_vk_out, 32'hAB);
        tick("fwd_drop");

        // Fill every slot waiting on tag 1; a further dispatch is ignored.
        for (int i = 0; i < RS_SIZE; i++) begin
            set_disp(OP_ADD, 32'(i), 1'b1, 4'd1, 32'(i), 1'b0, 4'd0, 32'd0, 4'(i));
            tick("fill");
        end
        idle();
        check("fill_full", 32'(full_out), 32'd1);
        set_disp(OP_ADD, 32'd99, 1'b0, 4'd0, 32'd99, 1'b0, 4'd0, 32'd0, 4'd9);
        tick("fill_extra"); idle();
        check("extra_full", 32'(full_out), 32'd1);
        alu_cdb_valid_in = 1'b1; alu_cdb_rob_id_in = 4'd1; alu_cdb_data_in = 32'h100;
        tick("fill_wake"); idle();
        for (int i = 0; i < RS_SIZE; i++) begin
            tick("drain");
            check("drain_valid", 32'(issue_valid_out), 32'd1);
            check("drain_rob", 32'(issue_rob_id_out), 32'(i));
            check("drain_vj", issue_vj_out, 32'h100);
            if (i == 0) check("drain_full_low", 32'(full_out), 32'd0);
        end
        tick("drain_end");
        check("no_extra_issue", 32'(issue_valid_out), 32'd0);

        // Flush beats a same-cycle dispatch and kills waiting entries.
        for (int i = 0; i < 4; i++) begin
            set_disp(OP_SUB, 32'd0, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'd0, 4'(i + 8));
            tick("pre_flush");
        end
        set_disp(OP_ADD, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 4'd15);
        clr_in = 1'b1;
        tick("flush"); idle();
        check("flush_valid", 32'(issue_valid_out), 32'd0);
        check("flush_full", 32'(full_out), 32'd0);
        alu_cdb_valid_in = 1'b1; alu_cdb_rob_id_in = 4'd5; alu_cdb_data_in = 32'h55;
        tick("post_flush_wake"); idle();
        repeat (3) begin
            tick("post_flush");
            check("flush_no_issue", 32'(issue_valid_out), 32'd0);
        end

        // Freeze with a ready entry, then an asynchronous reset mid-flight.
        set_disp(OP_ADD, 32'h11, 1'b0, 4'd0, 32'h22, 1'b0, 4'd0, 32'h33, 4'd7);
        tick("frz_disp"); idle();
        set_disp(OP_SUB, 32'd0, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd0, 4'd8);
        rdy_in = 1'b0;
        repeat (3) begin
            tick("frozen");
            check("frozen_valid", 32'(issue_valid_out), 32'd0);
        end
        idle();
        set_disp(OP_SUB, 32'd0, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd0, 4'd8);
        tick("thaw"); idle();
        check("thaw_valid", 32'(issue_valid_out), 32'd1);
        check("thaw_rob", 32'(issue_rob_id_out), 32'd7);
        check("thaw_imm", issue_imm_out, 32'h33);
        rst_in = 1'b1;
        m_reset();
        #1;
        check("async_rst_valid", 32'(issue_valid_out), 32'd0);
        compare_all("async_rst");
        #2 rst_in = 1'b0;
        alu_cdb_valid_in = 1'b1; alu_cdb_rob_id_in = 4'd9; alu_cdb_data_in = 32'h99;
        tick("rst_wake"); idle();
        tick("rst_after");
        check("rst_no_issue", 32'(issue_valid_out), 32'd0);

        // Randomized traffic with small tag space so wakeups and collisions are common.
        for (int c = 0; c < 600; c++) begin
            rdy_in           = ($urandom % 8) != 0;
            clr_in           = ($urandom % 50) == 0;
            disp_valid_in    = (($urandom % 2) == 0) && (count_busy() != RS_SIZE);
            disp_op_in       = 6'($urandom);
            disp_vj_in       = $urandom;
            disp_vk_in       = $urandom;
            disp_qj_pending_in = ($urandom % 2) == 0;
            disp_qk_pending_in = ($urandom % 2) == 0;
            disp_qj_in       = 4'($urandom % 4);
            disp_qk_in       = 4'($urandom % 4);
            disp_imm_in      = $urandom;
            disp_rob_id_in   = 4'($urandom);
            alu_cdb_valid_in = ($urandom % 3) == 0;
            alu_cdb_rob_id_in = 4'($urandom % 4);
            alu_cdb_data_in  = $urandom;
            lsb_cdb_valid_in = ($urandom % 3) == 0;
            lsb_cdb_rob_id_in = 4'($urandom % 4);
            lsb_cdb_data_in  = $urandom;
            tick("rnd");
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station and issue scheduler for the combinational integer ALU.
- Buffers dispatched ALU instructions until both source operands are available, snooping the ALU and LSB result broadcasts to fill them.
- Issues at most one ready instruction per cycle to the ALU through registered outputs.
- Sits between the decoder/dispatcher and the ALU; the ROB drives the flush.

Parameters:
- RS_SIZE, 8, number of entries; power of two, at least 2.
- DATA_WIDTH, 32, operand and immediate width.
- ROB_WIDTH, 4, ROB tag width.
- OP_WIDTH, 6, internal opcode width, shared encoding with the ALU.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  global enable; low freezes all state
- clr_in  input  1  synchronous flush from ROB (mispredict)
- disp_valid_in  input  1  dispatch request this cycle
- disp_op_in  input  OP_WIDTH  opcode
- disp_vj_in / disp_vk_in  input  DATA_WIDTH  operand values, valid when not pending
- disp_qj_pending_in / disp_qk_pending_in  input  1  operand awaits a ROB result
- disp_qj_in / disp_qk_in  input  ROB_WIDTH  producer tags
- disp_imm_in  input  DATA_WIDTH  immediate
- disp_rob_id_in  input  ROB_WIDTH  destination ROB tag
- full_out  output  1  no free entry
- alu_cdb_valid_in  input  1  ALU broadcast valid
- alu_cdb_rob_id_in  input  ROB_WIDTH  tag
- alu_cdb_data_in  input  DATA_WIDTH  result
- lsb_cdb_valid_in  input  1  LSB broadcast valid
- lsb_cdb_rob_id_in  input  ROB_WIDTH  tag
- lsb_cdb_data_in  input  DATA_WIDTH  result
- issue_valid_out  output  1  to ALU rdy_rs_in
- issue_op_out  output  OP_WIDTH  opcode
- issue_vj_out / issue_vk_out / issue_imm_out  output  DATA_WIDTH  operands
- issue_rob_id_out  output  ROB_WIDTH  tag

Behaviour:
- Clock and reset: clk_in is the single clock. rst_in is asynchronous, active-high.
- Reset values: all entries not busy, issue_valid_out=0, all issue data outputs 0, full_out=0.
- Entry state: busy, op, vj, qj, qj_pend, vk, qk, qk_pend, imm, rob_id.
- full_out: combinational; high iff every entry is busy in the current register state. An entry freed by issue this cycle does not lower full_out until the next cycle.
- Dispatch:
  - On disp_valid_in && !full_out, write the lowest-index free entry at the clock edge.
  - Dispatch while full_out is high is ignored and leaves state unchanged; the dispatcher must not do this.
- Dispatch forwarding: if an operand is pending and a same-cycle CDB tag matches, capture the CDB data and store the operand as not pending.
- Wakeup:
  - For each busy entry with a pending operand whose tag matches a valid CDB tag, latch the data and clear the pending flag.
  - If both CDBs match the same tag, ALU data wins.
- Selection:
  - An entry is eligible when busy && !qj_pend && !qk_pend, evaluated on current register state.
  - Lowest eligible index wins.
  - Entries dispatched or woken at edge N become eligible in the cycle after edge N.
- Issue:
  - At the edge, if an eligible entry exists: load the issue registers from it, set issue_valid_out=1 and clear the entry's busy flag.
  - Otherwise issue_valid_out=0 and the data outputs hold their previous values.
  - issue_valid_out is high for exactly one cycle per issued instruction.
  - Minimum dispatch-to-issue latency is 2 edges: written at edge N, issued at edge N+1.
  - ALU result appears combinationally while issue_valid_out is high.
- Simultaneous events:
  - Dispatch, issue and wakeup may occur in the same cycle on different entries.
  - The issuing entry cannot also be the dispatch target, because free-slot selection uses current state.
- Flush:
  - clr_in with rdy_in high clears all busy flags and issue_valid_out at the next edge.
  - Flush overrides same-cycle dispatch, wakeup and issue.
- Freeze: rdy_in low holds every register, including issue_valid_out. rst_in overrides rdy_in.
- Mid-operation reset: rst_in asserted at any time returns all state to reset values immediately, regardless of in-flight entries.

Test Plan:
- Reset, then dispatch ADD, vj=5, vk=7, both ready, rob_id=3 → issue_valid_out=1 with op=ADD, vj=5, vk=7, rob_id=3 one edge after dispatch, low on the following edge.
- Dispatch SUB with qj pending on tag 2; three cycles later alu_cdb (tag 2, data 0x10) → issue one edge after wakeup with vj=0x10.
- Dispatch with qk pending on tag 6 in the same cycle lsb_cdb broadcasts tag 6, data 0xAB → stored ready; issues next edge with vk=0xAB.
- Fill 8 entries, all waiting on tag 1 → full_out=1 and a 9th dispatch is ignored. Broadcast tag 1 → entries issue in index order 0..7 on consecutive cycles; full_out falls the cycle after the first issue.
- 4 busy entries, then clr_in=1 together with a dispatch → next cycle no entries busy, issue_valid_out=0, full_out=0, and no later issue occurs.
- Entry ready, rdy_in held low for 3 cycles → no issue and outputs frozen; issues on the first edge with rdy_in high. Asserting rst_in mid-sequence clears issue_valid_out without waiting for a clock edge.
